// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and types for the memory bus controller and
// related sequencers.
package cpu_pkg;

  localparam int unsigned DEF_ADDR_W = 9;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned MAX_WAIT   = 15;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Counter load value for a requested wait length: 0 behaves as 1 and
  // anything above MAX_WAIT saturates.
  function automatic logic [CNT_W-1:0] wait_load(input int unsigned cycles);
    if (cycles == 0)
      return '0;
    else if (cycles > MAX_WAIT)
      return CNT_W'(MAX_WAIT - 1);
    else
      return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter used to time bus strobes.
// Ports: clk, clr (async, active-high), load/load_val (preset),
//        dec (count down, stops at zero), zero_c (count is zero).
module mem_wait_counter
  import cpu_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] cnt;

  // Count register; load has priority, decrement saturates at zero.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - W'(1);
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Sequences one RAM read or write per request: IDLE -> SETUP -> ACCESS
// (WAIT_CYCLES cycles of strobe) -> DONE.
// Ports: clk, clr (async, active-high); req/we/addr_in/wdata request side;
//        busy, done, rdata status/result; ram_read/ram_write/ram_addr/
//        ram_wdata/ram_rdata RAM side.
module mem_bus_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

  state_t state;
  state_t state_nxt;
  logic   we_q;
  logic   cnt_zero;
  logic   cnt_load;
  logic   cnt_dec;

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic; req is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (cnt_zero) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign cnt_load = (state == ST_SETUP);
  assign cnt_dec  = (state == ST_ACCESS);

  mem_wait_counter #(
    .W (CNT_W)
  ) u_wait (
    .clk      (clk),
    .clr      (clr),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (WAIT_LOAD),
    .zero_c   (cnt_zero)
  );

  // Request capture and read-data capture on the final ACCESS edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      we_q      <= 1'b0;
      rdata     <= '0;
    end else begin
      if ((state == ST_IDLE) && req) begin
        ram_addr  <= addr_in;
        ram_wdata <= wdata;
        we_q      <= we;
      end
      if ((state == ST_ACCESS) && cnt_zero && !we_q)
        rdata <= ram_rdata;
    end
  end

  // Decoded from the state register so a reset drops them immediately.
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign ram_read  = (state == ST_ACCESS) && !we_q;
  assign ram_write = (state == ST_ACCESS) &&  we_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench: two controllers (WAIT_CYCLES 1 and 3) share the request
// inputs, each driving its own RAM model.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        req1, req3;
  logic        we;
  logic [8:0]  addr_in;
  logic [31:0] wdata;

  logic        busy1, done1, ram_read1, ram_write1;
  logic [31:0] rdata1, ram_wdata1, ram_rdata1;
  logic [8:0]  ram_addr1;
  logic        busy3, done3, ram_read3, ram_write3;
  logic [31:0] rdata3, ram_wdata3, ram_rdata3;
  logic [8:0]  ram_addr3;

  logic        ovr;
  logic [31:0] ovr_val;
  logic [31:0] mem1 [512];
  logic [31:0] mem3 [512];
  logic        loaded = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .clr(clr), .req(req1), .we(we), .addr_in(addr_in), .wdata(wdata),
    .busy(busy1), .done(done1), .rdata(rdata1), .ram_read(ram_read1),
    .ram_write(ram_write1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
    .ram_rdata(ram_rdata1));

  mem_bus_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .clr(clr), .req(req3), .we(we), .addr_in(addr_in), .wdata(wdata),
    .busy(busy3), .done(done3), .rdata(rdata3), .ram_read(ram_read3),
    .ram_write(ram_write3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
    .ram_rdata(ram_rdata3));

  // RAM models: asynchronous read, synchronous write, preloaded on first edge.
  assign ram_rdata1 = ovr ? ovr_val : mem1[ram_addr1];
  assign ram_rdata3 = ovr ? ovr_val : mem3[ram_addr3];

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 512; i++) begin
        mem1[i] <= 32'h1000_0000 + 32'(i);
        mem3[i] <= 32'h1000_0000 + 32'(i);
      end
      mem1[511] <= 32'h1234_5678;
      mem3[511] <= 32'h1234_5678;
      loaded    <= 1'b1;
    end else begin
      if (ram_write1) mem1[ram_addr1] <= ram_wdata1;
      if (ram_write3) mem3[ram_addr3] <= ram_wdata3;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One transaction on both controllers; optional stray req at cycle inj_k.
  task automatic txn(input string tag, input logic w, input logic [8:0] a,
                     input logic [31:0] d, input logic [31:0] exp_r, input int inj_k);
    int   dk1, dk3, nd1, nd3, ns1, ns3, nx1, nx3;
    logic aok1, aok3;
    dk1 = 0; dk3 = 0; nd1 = 0; nd3 = 0; ns1 = 0; ns3 = 0; nx1 = 0; nx3 = 0;
    aok1 = 1'b1; aok3 = 1'b1;
    @(negedge clk);
    req1 = 1'b1; req3 = 1'b1; we = w; addr_in = a; wdata = d;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req1 = 1'b0; req3 = 1'b0; we = ~w; addr_in = ~a; wdata = ~d;
      end
      if (inj_k != 0 && k == inj_k) begin
        req1 = 1'b1; req3 = 1'b1; we = 1'b1; addr_in = 9'h010; wdata = 32'hBAD0_BAD0;
      end
      if (inj_k != 0 && k == inj_k + 1) begin
        req1 = 1'b0; req3 = 1'b0;
      end
      if (done1) begin nd1++; if (dk1 == 0) dk1 = k; end
      if (done3) begin nd3++; if (dk3 == 0) dk3 = k; end
      if (ram_read1 || ram_write1) begin
        if (ram_write1 == w && ram_read1 == ~w) ns1++; else nx1++;
      end
      if (ram_read3 || ram_write3) begin
        if (ram_write3 == w && ram_read3 == ~w) ns3++; else nx3++;
      end
      if (busy1 && (ram_addr1 !== a || ram_wdata1 !== d)) aok1 = 1'b0;
      if (busy3 && (ram_addr3 !== a || ram_wdata3 !== d)) aok3 = 1'b0;
      if (dk1 != 0 && dk3 != 0 && !busy1 && !busy3) break;
    end
    chk({tag, " w1 done latency"}, 32'(dk1), 32'd3);
    chk({tag, " w3 done latency"}, 32'(dk3), 32'd5);
    chk({tag, " w1 done pulses"}, 32'(nd1), 32'd1);
    chk({tag, " w3 done pulses"}, 32'(nd3), 32'd1);
    chk({tag, " w1 strobe cycles"}, 32'(ns1), 32'd1);
    chk({tag, " w3 strobe cycles"}, 32'(ns3), 32'd3);
    chk({tag, " w1 wrong strobe"}, 32'(nx1), 32'd0);
    chk({tag, " w3 wrong strobe"}, 32'(nx3), 32'd0);
    chk({tag, " w1 addr/data stable"}, 32'(aok1), 32'd1);
    chk({tag, " w3 addr/data stable"}, 32'(aok3), 32'd1);
    chk({tag, " w1 ram_addr held"}, 32'(ram_addr1), 32'(a));
    chk({tag, " w3 ram_addr held"}, 32'(ram_addr3), 32'(a));
    chk({tag, " w1 rdata"}, rdata1, exp_r);
    chk({tag, " w3 rdata"}, rdata3, exp_r);
  endtask

  typedef struct {
    logic        w;
    logic [8:0]  a;
    logic [31:0] d;
    logic [31:0] exp_r;
    int          inj;
  } vec_t;

  vec_t tv [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int f1a, f1b, f3a, f3b, nd1, nd3, nd;
    logic [31:0] r1a, r3a;
    logic prev1, prev3, got1, got3;

    tv[0] = '{1'b1, 9'h005, 32'hDEAD_BEEF, 32'h0000_0000, 0};
    tv[1] = '{1'b0, 9'h005, 32'h0000_0000, 32'hDEAD_BEEF, 0};
    tv[2] = '{1'b0, 9'h1FF, 32'h0000_0000, 32'h1234_5678, 0};
    tv[3] = '{1'b1, 9'h020, 32'hCAFE_F00D, 32'h1234_5678, 2};
    tv[4] = '{1'b0, 9'h010, 32'h0000_0000, 32'h1000_0010, 0};
    tv[5] = '{1'b0, 9'h020, 32'h0000_0000, 32'hCAFE_F00D, 0};
    tv[6] = '{1'b1, 9'h000, 32'h0A0B_0C0D, 32'hCAFE_F00D, 0};
    tv[7] = '{1'b0, 9'h000, 32'h0000_0000, 32'h0A0B_0C0D, 0};

    clr = 1'b1; req1 = 1'b0; req3 = 1'b0; we = 1'b0; addr_in = '0; wdata = '0;
    ovr = 1'b0; ovr_val = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", {30'd0, busy1, busy3}, 32'd0);
    chk("reset done", {30'd0, done1, done3}, 32'd0);
    chk("reset strobes", {28'd0, ram_read1, ram_write1, ram_read3, ram_write3}, 32'd0);
    chk("reset w1 rdata", rdata1, 32'd0);
    chk("reset w3 rdata", rdata3, 32'd0);
    chk("reset ram_addr", {14'd0, ram_addr1, ram_addr3}, 32'd0);
    chk("reset ram_wdata", ram_wdata1 | ram_wdata3, 32'd0);
    clr = 1'b0;

    for (int i = 0; i < 8; i++)
      txn($sformatf("row%0d", i), tv[i].w, tv[i].a, tv[i].d, tv[i].exp_r, tv[i].inj);

    // Captured read data must ignore later RAM output changes and writes.
    ovr_val = 32'hFFFF_0000; ovr = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold w1 rdata", rdata1, 32'h0A0B_0C0D);
    chk("hold w3 rdata", rdata3, 32'h0A0B_0C0D);
    txn("write after read", 1'b1, 9'h030, 32'h55AA_55AA, 32'h0A0B_0C0D, 0);
    ovr = 1'b0;

    // Reset in the middle of ACCESS of a read.
    @(negedge clk);
    req1 = 1'b1; req3 = 1'b1; we = 1'b0; addr_in = 9'h003;
    @(negedge clk);
    req1 = 1'b0; req3 = 1'b0;
    @(negedge clk);
    chk("pre-clr strobes", {30'd0, ram_read1, ram_read3}, 32'd3);
    #2 clr = 1'b1;
    #1;
    chk("clr ram_read", {30'd0, ram_read1, ram_read3}, 32'd0);
    chk("clr busy", {30'd0, busy1, busy3}, 32'd0);
    chk("clr w1 rdata", rdata1, 32'd0);
    chk("clr w3 rdata", rdata3, 32'd0);
    chk("clr ram_addr", {14'd0, ram_addr1, ram_addr3}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done1 || done3) nd++;
    end
    chk("no done after abort", 32'(nd), 32'd0);
    txn("read after clr", 1'b0, 9'h003, 32'h0, 32'h1000_0003, 0);

    // Back-to-back reads with req held high.
    f1a = 0; f1b = 0; f3a = 0; f3b = 0; nd1 = 0; nd3 = 0;
    r1a = '0; r3a = '0; prev1 = 1'b0; prev3 = 1'b0; got1 = 1'b0; got3 = 1'b0;
    @(negedge clk);
    req1 = 1'b1; req3 = 1'b1; we = 1'b0; addr_in = 9'h000;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) addr_in = 9'h001;
      if (k == 5) req1 = 1'b0;
      if (k == 7) req3 = 1'b0;
      if (prev1 && !got1) begin r1a = rdata1; got1 = 1'b1; end
      if (prev3 && !got3) begin r3a = rdata3; got3 = 1'b1; end
      if (done1) begin nd1++; if (f1a == 0) f1a = k; else if (f1b == 0) f1b = k; end
      if (done3) begin nd3++; if (f3a == 0) f3a = k; else if (f3b == 0) f3b = k; end
      prev1 = done1; prev3 = done3;
    end
    chk("b2b w1 first done", 32'(f1a), 32'd3);
    chk("b2b w1 spacing", 32'(f1b - f1a), 32'd4);
    chk("b2b w3 first done", 32'(f3a), 32'd5);
    chk("b2b w3 spacing", 32'(f3b - f3a), 32'd6);
    chk("b2b w1 done count", 32'(nd1), 32'd2);
    chk("b2b w3 done count", 32'(nd3), 32'd2);
    chk("b2b w1 first rdata", r1a, 32'h0A0B_0C0D);
    chk("b2b w3 first rdata", r3a, 32'h0A0B_0C0D);
    chk("b2b w1 second rdata", rdata1, 32'h1000_0001);
    chk("b2b w3 second rdata", rdata3, 32'h1000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
